// File: rtl/sram_spi_pkg.sv
// Shared definitions for the M23A640 SPI SRAM master: opcodes, address width,
// FSM state encoding and the 32-bit command frame builder.
package sram_spi_pkg;

    localparam int          ADDR_W = 13;
    localparam logic [7:0]  RD_OP  = 8'h03;
    localparam logic [7:0]  WR_OP  = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CS_END,
        DESEL
    } state_t;

    // Frame is opcode, 16-bit zero-extended address, then the data byte
    // (reads send zeros while the device returns its byte).
    function automatic logic [31:0] build_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        wdata
    );
        return {(wr ? WR_OP : RD_OP), {(16 - ADDR_W){1'b0}}, addr, (wr ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/sram_spi_clkgen.sv
// SPI sck divider: toggles sck every CLK_DIV clk cycles while run is high,
// pauses in place on freeze, and flags the edge about to happen on this clk.
module sram_spi_clkgen
    import sram_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic run,
    input  logic freeze,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    logic [3:0] r_div_cnt;
    logic       r_sck;
    logic       w_tick;

    // Strobes are combinational so the master acts on the same clk edge
    // that moves sck.
    assign w_tick   = run & ~freeze & (r_div_cnt == 4'(CLK_DIV - 1));
    assign rise_stb = w_tick & ~r_sck;
    assign fall_stb = w_tick &  r_sck;
    assign sck      = r_sck;

    always_ff @(posedge clk) begin
        if (!rstb || !run) begin
            r_div_cnt <= 4'd0;
            r_sck     <= 1'b0;
        end else if (!freeze) begin
            if (r_div_cnt == 4'(CLK_DIV - 1)) begin
                r_div_cnt <= 4'd0;
                r_sck     <= ~r_sck;
            end else begin
                r_div_cnt <= r_div_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sram_spi_master.sv
// Single-byte read/write SPI master for the M23A640 SRAM (mode 0, MSB first).
// Optional HOLD pin support is compiled in with macro SRAM_SPI_HOLD_EN.
module sram_spi_master
    import sram_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    input  logic              hold_req,
    output logic              csb,
    output logic              sck,
    output logic              si,
    output logic              holdb,
    input  logic              so
);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_csb;
    logic        r_si;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic [7:0]  r_rx;
    logic [31:0] r_tx;
    logic [4:0]  r_bit_cnt;
    logic [3:0]  r_end_cnt;
    logic        r_write;

    logic        w_run;
    logic        w_freeze;
    logic        w_sck;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_frame;

    assign w_run   = (r_state == SHIFT);
    assign w_frame = build_frame(req_write, req_addr, req_wdata);

`ifdef SRAM_SPI_HOLD_EN
    logic r_hold;
    logic w_hold_enter;

    // Hold only engages with sck low so the device never sees a stretched high phase.
    assign w_hold_enter = (r_state == SHIFT) & hold_req & ~w_sck & ~r_hold;
    assign w_freeze     = r_hold | w_hold_enter;
    assign holdb        = ~r_hold;

    always_ff @(posedge clk) begin
        if (!rstb || r_state != SHIFT) begin
            r_hold <= 1'b0;
        end else if (w_hold_enter) begin
            r_hold <= 1'b1;
        end else if (r_hold && !hold_req) begin
            r_hold <= 1'b0;
        end
    end
`else
    logic w_unused_hold;

    assign w_unused_hold = hold_req;
    assign w_freeze      = 1'b0;
    assign holdb         = 1'b1;
`endif

    sram_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rstb     (rstb),
        .run      (w_run),
        .freeze   (w_freeze),
        .sck      (w_sck),
        .rise_stb (w_rise),
        .fall_stb (w_fall)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_csb       <= 1'b1;
            r_si        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rx        <= 8'h00;
            r_tx        <= 32'h0;
            r_bit_cnt   <= 5'd0;
            r_end_cnt   <= 4'd0;
            r_write     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_state     <= SHIFT;
                        r_csb       <= 1'b0;
                        r_tx        <= w_frame;
                        r_si        <= w_frame[31];
                        r_write     <= req_write;
                        r_bit_cnt   <= 5'd0;
                        r_rx        <= 8'h00;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_rise && r_bit_cnt >= 5'd24) begin
                        r_rx <= {r_rx[6:0], so};
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == 5'd31) begin
                            r_state   <= CS_END;
                            r_si      <= 1'b0;
                            r_end_cnt <= 4'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_tx      <= {r_tx[30:0], 1'b0};
                            r_si      <= r_tx[30];
                        end
                    end
                end
                CS_END: begin
                    // One extra sck half-period of csb low after the last falling edge.
                    if (r_end_cnt == 4'(CLK_DIV - 1)) begin
                        r_csb       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_write ? 8'h00 : r_rx;
                        r_state     <= DESEL;
                    end else begin
                        r_end_cnt <= r_end_cnt + 4'd1;
                    end
                end
                DESEL: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign csb       = r_csb;
    assign sck       = w_sck;
    assign si        = r_si;

endmodule

// File: tb/tb_sram_spi_master.sv
// Directed bench for sram_spi_master (CLK_DIV=2 and CLK_DIV=1 instances) with a
// small M23A640 behavioural model on a pin mux selected by sel.
module tb_sram_spi_master;

    logic        clk = 1'b0;
    logic        rstb;
    logic        req_valid;
    logic        req_write;
    logic [12:0] req_addr;
    logic [7:0]  req_wdata;
    logic        hold_req;
    logic        so_m;
    bit          sel;

    logic        rdy0, rv0, cs0, sck0, si0, hb0;
    logic        rdy1, rv1, cs1, sck1, si1, hb1;
    logic [7:0]  rd0, rd1;
    logic        vin0, vin1;

    logic        m_csb, m_sck, m_si, m_holdb, m_ready, m_rsp, m_vin;
    logic [7:0]  m_rdata;

    int n_vec = 0;
    int n_err = 0;
    int csb_low, n_rise, rsp_cnt, acc_cnt;

    logic [7:0]  mem [0:8191];
    logic [31:0] m_cap;
    int          m_bits;
    logic        m_isrd;
    logic [7:0]  m_byte;

    always #5 clk = ~clk;

    assign vin0    = req_valid & ~sel;
    assign vin1    = req_valid &  sel;
    assign m_csb   = sel ? cs1  : cs0;
    assign m_sck   = sel ? sck1 : sck0;
    assign m_si    = sel ? si1  : si0;
    assign m_holdb = sel ? hb1  : hb0;
    assign m_ready = sel ? rdy1 : rdy0;
    assign m_rsp   = sel ? rv1  : rv0;
    assign m_rdata = sel ? rd1  : rd0;
    assign m_vin   = sel ? vin1 : vin0;

    sram_spi_master #(.CLK_DIV(2)) dut0 (
        .clk(clk), .rstb(rstb), .req_valid(vin0), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .hold_req(hold_req),
        .csb(cs0), .sck(sck0), .si(si0), .holdb(hb0), .so(so_m)
    );

    sram_spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rstb(rstb), .req_valid(vin1), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .hold_req(1'b0),
        .csb(cs1), .sck(sck1), .si(si1), .holdb(hb1), .so(so_m)
    );

    // Device model: samples si on sck rise, drives so after sck fall.
    always @(posedge m_sck or posedge m_csb) begin
        if (m_csb) begin
            m_bits = 0;
        end else begin
            m_cap  = {m_cap[30:0], m_si};
            m_bits = m_bits + 1;
            n_rise = n_rise + 1;
            if (m_bits == 32 && m_cap[31:24] == 8'h02)
                mem[m_cap[20:8]] = m_cap[7:0];
        end
    end

    always @(negedge m_sck) begin
        if (!m_csb) begin
            if (m_bits == 24) begin
                m_isrd = (m_cap[23:16] == 8'h03);
                m_byte = mem[m_cap[12:0]];
            end
            if (m_isrd && m_bits >= 24 && m_bits <= 31)
                so_m = m_byte[31 - m_bits];
        end
    end

    always @(posedge clk) begin
        if (!m_csb)            csb_low = csb_low + 1;
        if (m_rsp)             rsp_cnt = rsp_cnt + 1;
        if (m_vin && m_ready)  acc_cnt = acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        csb_low = 0; n_rise = 0; rsp_cnt = 0; acc_cnt = 0;
    endtask

    task automatic issue(input string tag, input logic wr, input logic [12:0] a, input logic [7:0] d);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = (m_ready === 1'b1);
        end
        check({tag, "_ready"}, found, 1);
        req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        bit found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            found = (m_rsp === 1'b1);
            if (!found) @(negedge clk);
        end
        check({tag, "_rsp_seen"}, found, 1);
    endtask

    initial begin
        bit hold_on;
`ifdef SRAM_SPI_HOLD_EN
        hold_on = 1'b1;
`else
        hold_on = 1'b0;
`endif
        rstb = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; hold_req = 1'b0; so_m = 1'b0; sel = 1'b0;
        m_cap = '0; m_bits = 0; m_isrd = 1'b0; m_byte = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0ABC] = 8'h11;
        mem[13'h1FFF] = 8'h96;
        clear_counts();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csb",   m_csb,   1);
        check("rst_sck",   m_sck,   0);
        check("rst_si",    m_si,    0);
        check("rst_holdb", m_holdb, 1);
        check("rst_ready", m_ready, 0);
        check("rst_rsp",   m_rsp,   0);
        check("rst_rdata", m_rdata, 8'h00);
        rstb = 1'b1;
        @(negedge clk);
        check("rst_ready_after", m_ready, 1);

        // Write 0x0155 <- 0xA5
        clear_counts();
        issue("wr1", 1'b1, 13'h0155, 8'hA5);
        wait_rsp("wr1");
        check("wr1_rdata", m_rdata, 8'h00);
        check("wr1_ready_desel", m_ready, 0);
        repeat (2) @(negedge clk);
        check("wr1_frame", m_cap, 32'h020155A5);
        check("wr1_csb_low", csb_low, 130);
        check("wr1_rises", n_rise, 32);
        check("wr1_rsp_cnt", rsp_cnt, 1);
        check("wr1_mem", mem[13'h0155], 8'hA5);

        // Read back 0x0155
        clear_counts();
        issue("rd1", 1'b0, 13'h0155, 8'hEE);
        wait_rsp("rd1");
        check("rd1_rdata", m_rdata, 8'hA5);
        repeat (2) @(negedge clk);
        check("rd1_frame", m_cap, 32'h03015500);
        check("rd1_rsp_cnt", rsp_cnt, 1);
        check("rd1_rdata_hold", m_rdata, 8'hA5);

        // req_valid held high; fields change after acceptance
        clear_counts();
        issue("hv_pre", 1'b0, 13'h0000, 8'h00);
        wait_rsp("hv_pre");
        repeat (2) @(negedge clk);
        req_write = 1'b1; req_addr = 13'h0002; req_wdata = 8'h5A; req_valid = 1'b1;
        clear_counts();
        @(negedge clk);
        req_addr = 13'h1FFF; req_wdata = 8'hFF; req_write = 1'b0;
        wait_rsp("hv");
        check("hv_ready_desel", m_ready, 0);
        req_valid = 1'b0;
        @(negedge clk);
        check("hv_ready_idle", m_ready, 1);
        check("hv_accepts", acc_cnt, 1);
        check("hv_frame", m_cap, 32'h0200025A);
        check("hv_rdata", m_rdata, 8'h00);

        // Reset at bit 12 of a write
        clear_counts();
        issue("ab", 1'b1, 13'h0ABC, 8'h77);
        for (int i = 0; i < 400 && m_bits < 13; i++) @(negedge clk);
        check("ab_bit12", m_bits, 13);
        rstb = 1'b0;
        @(negedge clk);
        check("ab_csb", m_csb, 1);
        check("ab_sck", m_sck, 0);
        @(negedge clk);
        check("ab_ready", m_ready, 0);
        rstb = 1'b1;
        @(negedge clk);
        check("ab_ready_after", m_ready, 1);
        repeat (150) @(negedge clk);
        check("ab_no_rsp", rsp_cnt, 0);
        check("ab_mem", mem[13'h0ABC], 8'h11);
        clear_counts();
        issue("ab_next", 1'b0, 13'h0155, 8'h00);
        wait_rsp("ab_next");
        check("ab_next_rdata", m_rdata, 8'hA5);

        // hold_req pulse of 20 clk around bit 10 of a write
        repeat (2) @(negedge clk);
        clear_counts();
        issue("hd", 1'b1, 13'h0123, 8'hC3);
        for (int i = 0; i < 400 && !(m_bits == 10 && m_sck == 1'b0); i++) @(negedge clk);
        check("hd_bit10", m_bits, 10);
        hold_req = 1'b1;
        repeat (10) @(negedge clk);
        check("hd_holdb", m_holdb, hold_on ? 1'b0 : 1'b1);
        if (hold_on) check("hd_sck_low", m_sck, 0);
        repeat (10) @(negedge clk);
        hold_req = 1'b0;
        wait_rsp("hd");
        repeat (2) @(negedge clk);
        check("hd_csb_low", csb_low, hold_on ? 151 : 130);
        check("hd_frame", m_cap, 32'h020123C3);
        check("hd_mem", mem[13'h0123], 8'hC3);
        check("hd_holdb_end", m_holdb, 1);

        // CLK_DIV=1 instance: read top address
        sel = 1'b1;
        repeat (2) @(negedge clk);
        clear_counts();
        issue("d1", 1'b0, 13'h1FFF, 8'h00);
        wait_rsp("d1");
        check("d1_rdata", m_rdata, 8'h96);
        repeat (2) @(negedge clk);
        check("d1_frame", m_cap, 32'h031FFF00);
        check("d1_csb_low", csb_low, 65);
        check("d1_rises", n_rise, 32);
        check("d1_rsp_cnt", rsp_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
